sha_add_sequencer: RTL

//  Multi-operand modular adder controller for the SHA datapath. Two requesters
//  (e.g. round-function T1/T2 unit and message-schedule unit) share one external
//  32-bit ripple adder (Add). Each requester streams a packet of operands.
//  The block sums the packet mod 2^32 on the shared adder and returns one result.
//  The external adder is combinational with gate delays, so its sum is sampled

---
 rtl/sha_add_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sha_add_sequencer.sv
// Multi-operand modular adder controller. Two requesters share one external
// combinational 32-bit adder; each streams a packet of operands and receives
// a single mod-2^32 sum. The adder output is sampled only after ADD_WAIT
// cycles of stable inputs so that the carry chain has settled.
module sha_add_sequencer #(
  parameter int unsigned ADD_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  op_valid,
  input  logic [1:0]  op_last,
  input  logic [31:0] op_data0,
  input  logic [31:0] op_data1,
  output logic [1:0]  op_ready,
  output logic [1:0]  res_valid,
  input  logic [1:0]  res_ready,
  output logic [31:0] res_data,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_s,
  output logic        busy,
  output logic        grant
);

  localparam int unsigned CntW = (ADD_WAIT > 1) ? $clog2(ADD_WAIT) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StFirst,
    StNext,
    StAdd,
    StDone
  } state_e;

  state_e        state;
  logic [31:0]   acc;
  logic [31:0]   opnd;
  logic [CntW-1:0] cnt;
  logic          last_r;
  logic          last_grant;

  logic          pick;
  logic [31:0]   data_g;
  logic          last_g;
  logic          take;

  // The adder operands are the accumulator and operand registers themselves,
  // so they stay stable for the whole settle window.
  assign add_a    = acc;
  assign add_b    = opnd;
  assign res_data = acc;

  // Round-robin: prefer the requester that did not own the previous packet.
  always_comb begin
    pick   = op_valid[~last_grant] ? ~last_grant : op_valid[1];
    data_g = grant ? op_data1 : op_data0;
    last_g = op_last[grant];
    take   = op_valid[grant] & op_ready[grant];
  end

  // Single FSM register block; all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      acc        <= '0;
      opnd       <= '0;
      cnt        <= '0;
      last_r     <= 1'b0;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      op_ready   <= 2'b00;
      res_valid  <= 2'b00;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (|op_valid) begin
            grant    <= pick;
            op_ready <= pick ? 2'b10 : 2'b01;
            busy     <= 1'b1;
            state    <= StFirst;
          end
        end
        StFirst: begin
          if (take) begin
            acc <= data_g;
            if (last_g) begin
              op_ready  <= 2'b00;
              res_valid <= grant ? 2'b10 : 2'b01;
              state     <= StDone;
            end else begin
              state <= StNext;
            end
          end
        end
        StNext: begin
          if (take) begin
            opnd     <= data_g;
            last_r   <= last_g;
            cnt      <= CntW'(ADD_WAIT - 1);
            op_ready <= 2'b00;
            state    <= StAdd;
          end
        end
        StAdd: begin
          if (cnt == '0) begin
            acc <= add_s;
            if (last_r) begin
              res_valid <= grant ? 2'b10 : 2'b01;
              state     <= StDone;
            end else begin
              op_ready <= grant ? 2'b10 : 2'b01;
              state    <= StNext;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        StDone: begin
          if (res_ready[grant]) begin
            res_valid  <= 2'b00;
            busy       <= 1'b0;
            last_grant <= grant;
            state      <= StIdle;
          end
        end
        default: begin
          state     <= StIdle;
          op_ready  <= 2'b00;
          res_valid <= 2'b00;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
